mm_stream_reader: RTL and testbench

Avalon-MM read initiator that fetches a programmed run of 32-bit words from a fixed-latency Avalon-MM slave, such as the SoC's small on-chip RAM, and presents them on a valid/ready stream toward the audio datapath. It sits between the on-chip memory's s2 port and the decoder/codec feed. It is credit-based: it never issues a read it cannot buffer, so returned data is never dropped.

---
 rtl/mm_stream_reader.sv | 105 ++++++++++
 tb/tb_mm_stream_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mm_stream_reader.sv
// mm_stream_reader: credit-based Avalon-MM read initiator feeding a show-ahead stream FIFO.
module mm_stream_reader #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] remain_q, remain_d;
  logic [CW-1:0] inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [READ_LATENCY-1:0] track_q, track_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic accept, push, pop;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign avm_address = addr_q;
  assign avm_chipselect = avm_read;
  assign avm_write = 1'b0;
  assign avm_byteenable = '1;
  assign st_valid = count_q != '0;
  assign st_data = st_valid ? mem_q[rd_q] : '0;
  // Credit uses registered counts only, so a pop in the same cycle frees nothing yet.
  assign avm_read = state_q == ISSUE && remain_q != '0 &&
                    ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH);
  always_comb begin
    accept = avm_read & ~avm_waitrequest;
    push = track_q[READ_LATENCY-1];
    pop = st_valid & st_ready;
    state_d = state_q;
    addr_d = addr_q;
    remain_d = remain_q;
    done_d = 1'b0;
    inflight_d = inflight_q + CW'(accept) - CW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    track_d = (track_q << 1) | READ_LATENCY'(accept);
    if (state_q == IDLE && start) begin
      if (word_count == '0) done_d = 1'b1;
      else begin
        addr_d = base_addr;
        remain_d = word_count;
        state_d = ISSUE;
      end
    end
    if (accept) begin
      addr_d = addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
      state_d = remain_q == (ADDR_W+1)'(1) ? DRAIN : state_q;
    end
    // Looking at next-cycle counts lets done land one cycle after the last pop.
    if (state_q == DRAIN && inflight_d == '0 && count_d == '0) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      remain_q <= '0;
      inflight_q <= '0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      track_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      remain_q <= remain_d;
      inflight_q <= inflight_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      track_q <= track_d;
      done_q <= done_d;
      if (push) mem_q[wr_q] <= avm_readdata;
    end
  end
endmodule

// File: tb/tb_mm_stream_reader.sv
// tb_mm_stream_reader: scoreboard bench; u0 uses a 4-deep FIFO, u1 a 2-deep one for backpressure.
module tb_mm_stream_reader;
  logic clk = 0, reset = 1, start = 0, st_ready = 0, waitreq = 0, sel = 0;
  logic [1:0] base = 0;
  logic [2:0] cnt = 0;
  logic busy0, done0, cs0, read0, wr0, sv0, busy1, done1, cs1, read1, wr1, sv1;
  logic [1:0] addr0, addr1;
  logic [3:0] be0, be1;
  logic [31:0] rdata0, rdata1, sd0, sd1;
  logic m_busy, m_done, m_cs, m_read, m_wr, m_valid;
  logic [1:0] m_addr;
  logic [3:0] m_be;
  logic [31:0] m_data;
  logic [31:0] ram [4];
  int cyc = 0, n_cmp = 0, n_err = 0;
  int n_acc, first_acc, last_acc, n_stall, n_pop, n_done, first_v, first_busy, n_busy;
  int t0, dt;
  logic [1:0] aq [$];
  logic [31:0] dq [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rdata0 <= ram[addr0];
    rdata1 <= ram[addr1];
  end
  mm_stream_reader u0 (
    .clk(clk), .reset(reset), .start(start & ~sel), .base_addr(base), .word_count(cnt),
    .busy(busy0), .done(done0), .avm_address(addr0), .avm_chipselect(cs0), .avm_read(read0),
    .avm_write(wr0), .avm_byteenable(be0), .avm_waitrequest(waitreq), .avm_readdata(rdata0),
    .st_data(sd0), .st_valid(sv0), .st_ready(st_ready));
  mm_stream_reader #(.FIFO_DEPTH(2)) u1 (
    .clk(clk), .reset(reset), .start(start & sel), .base_addr(base), .word_count(cnt),
    .busy(busy1), .done(done1), .avm_address(addr1), .avm_chipselect(cs1), .avm_read(read1),
    .avm_write(wr1), .avm_byteenable(be1), .avm_waitrequest(waitreq), .avm_readdata(rdata1),
    .st_data(sd1), .st_valid(sv1), .st_ready(st_ready));
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_cs = sel ? cs1 : cs0;
  assign m_read = sel ? read1 : read0;
  assign m_wr = sel ? wr1 : wr0;
  assign m_valid = sel ? sv1 : sv0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_be = sel ? be1 : be0;
  assign m_data = sel ? sd1 : sd0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    n_acc = 0; first_acc = -1; last_acc = -1; n_stall = 0; n_pop = 0;
    n_done = 0; first_v = -1; first_busy = -1; n_busy = 0;
  endtask
  task automatic push_exp(input int b, input int c);
    for (int i = 0; i < c; i++) begin
      aq.push_back(2'(b + i));
      dq.push_back(ram[(b + i) % 4]);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (m_read && !waitreq) begin
      chk("addr", 32'(m_addr), aq.size() != 0 ? 32'(aq.pop_front()) : 32'hdeadbeef);
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (m_read && waitreq) begin
      n_stall++;
      chk("hold", 32'(m_addr), aq.size() != 0 ? 32'(aq[0]) : 32'hdeadbeef);
    end
    if (m_valid && st_ready) begin
      chk("data", m_data, dq.size() != 0 ? dq.pop_front() : 32'hdeadbeef);
      n_pop++;
    end
    if (m_valid && first_v < 0) first_v = cyc;
    if (m_busy) begin
      n_busy++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (m_done) n_done++;
  end
  task automatic run(input int b, input int c, input int sa, input int sl, input int ra,
                     output int ts, output int dts);
    @(posedge clk); #1;
    clr();
    ts = cyc; base = 2'(b); cnt = 3'(c); start = 1;
    push_exp(b, c);
    dts = -1;
    for (int i = 0; i < 60 && dts < 0; i++) begin
      @(posedge clk); #1;
      start = (cyc - ts == ra);
      waitreq = (cyc - ts >= sa) && (cyc - ts < sa + sl);
      @(negedge clk);
      if (m_done) dts = cyc - ts;
    end
    start = 0; waitreq = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(m_busy), 0);
    chk({tag, "_done"}, 32'(m_done), 0);
    chk({tag, "_read"}, 32'(m_read), 0);
    chk({tag, "_cs"}, 32'(m_cs), 0);
    chk({tag, "_wr"}, 32'(m_wr), 0);
    chk({tag, "_be"}, 32'(m_be), 32'hf);
    chk({tag, "_addr"}, 32'(m_addr), 0);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_data"}, m_data, 0);
  endtask
  initial begin
    ram[0] = 32'h11111111; ram[1] = 32'h22222222; ram[2] = 32'h33333333; ram[3] = 32'h44444444;
    clr();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk_reset_vals("rst");
    st_ready = 1;
    run(0, 4, -1, 0, -1, t0, dt);
    chk("fr_done_t", 32'(dt), 7);
    chk("fr_busy_t", 32'(first_busy), 32'(t0 + 1));
    chk("fr_first_rd", 32'(first_acc), 32'(t0 + 1));
    chk("fr_last_rd", 32'(last_acc), 32'(t0 + 4));
    chk("fr_reads", 32'(n_acc), 4);
    chk("fr_valid_t", 32'(first_v), 32'(t0 + 3));
    chk("fr_ndone", 32'(n_done), 1);
    chk("fr_left", 32'(aq.size() + dq.size()), 0);
    run(3, 3, -1, 0, -1, t0, dt);
    chk("wr_done_t", 32'(dt), 6);
    chk("wr_reads", 32'(n_acc), 3);
    chk("wr_left", 32'(aq.size() + dq.size()), 0);
    run(0, 4, 2, 3, -1, t0, dt);
    chk("st_done_t", 32'(dt), 10);
    chk("st_stalls", 32'(n_stall), 3);
    chk("st_left", 32'(aq.size() + dq.size()), 0);
    run(1, 0, -1, 0, -1, t0, dt);
    chk("z_done_t", 32'(dt), 1);
    chk("z_reads", 32'(n_acc), 0);
    chk("z_busy", 32'(n_busy), 0);
    chk("z_ndone", 32'(n_done), 1);
    run(2, 4, -1, 0, 3, t0, dt);
    chk("sb_done_t", 32'(dt), 7);
    chk("sb_reads", 32'(n_acc), 4);
    chk("sb_ndone", 32'(n_done), 1);
    chk("sb_left", 32'(aq.size() + dq.size()), 0);
    @(posedge clk); #1;
    sel = 1; st_ready = 0;
    @(posedge clk); #1;
    clr();
    t0 = cyc; base = 0; cnt = 4; start = 1;
    push_exp(0, 4);
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_reads", 32'(n_acc), 2);
    chk("bp_read_low", 32'(m_read), 0);
    chk("bp_valid", 32'(m_valid), 1);
    @(posedge clk); #1 st_ready = 1;
    dt = -1;
    for (int i = 0; i < 40 && dt < 0; i++) begin
      @(negedge clk);
      if (m_done) dt = cyc - t0;
    end
    chk("bp_timeout", 32'(dt < 0), 0);
    chk("bp_pops", 32'(n_pop), 4);
    chk("bp_reads_all", 32'(n_acc), 4);
    chk("bp_left", 32'(aq.size() + dq.size()), 0);
    @(posedge clk); #1;
    sel = 0; st_ready = 0;
    @(posedge clk); #1;
    clr();
    t0 = cyc; base = 0; cnt = 4; start = 1;
    push_exp(0, 4);
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1;
    chk("mr_reads", 32'(n_acc), 2);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk_reset_vals("mr");
    aq.delete(); dq.delete();
    st_ready = 1; n_pop = 0;
    repeat (4) @(negedge clk);
    chk("mr_stale", 32'(n_pop), 0);
    chk("mr_valid", 32'(m_valid), 0);
    run(0, 4, -1, 0, -1, t0, dt);
    chk("mr_done_t", 32'(dt), 7);
    chk("mr_valid_t", 32'(first_v), 32'(t0 + 3));
    chk("mr_reads2", 32'(n_acc), 4);
    chk("mr_left", 32'(aq.size() + dq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
